// File: rtl/march_bist_pkg.sv
// March C- BIST shared types: FSM state, element index, op encoding and the
// per-element constant table (direction, op count, op sequence).
package march_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [2:0] elem_t;

    // bit1 = read, bit0 = data value (all-zeros / all-ones word)
    typedef enum logic [1:0] {
        W0 = 2'b00,
        W1 = 2'b01,
        R0 = 2'b10,
        R1 = 2'b11
    } op_t;

    typedef struct packed {
        logic down;     // 1 = address runs N-1..0
        logic two_ops;  // 0 = one op per address, 1 = two ops
        op_t  op0;
        op_t  op1;
    } elem_cfg_t;

    localparam int NUM_ELEM = 6;

    // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) down(r0)
    function automatic elem_cfg_t elem_cfg(input elem_t e);
        elem_cfg_t c;
        case (e)
            3'd0:    c = '{down: 1'b0, two_ops: 1'b0, op0: W0, op1: W0};
            3'd1:    c = '{down: 1'b0, two_ops: 1'b1, op0: R0, op1: W1};
            3'd2:    c = '{down: 1'b0, two_ops: 1'b1, op0: R1, op1: W0};
            3'd3:    c = '{down: 1'b1, two_ops: 1'b1, op0: R0, op1: W1};
            3'd4:    c = '{down: 1'b1, two_ops: 1'b1, op0: R1, op1: W0};
            default: c = '{down: 1'b1, two_ops: 1'b0, op0: R0, op1: R0};
        endcase
        return c;
    endfunction

    function automatic logic op_is_write(input op_t op);
        return (op == W0) || (op == W1);
    endfunction

    function automatic logic op_value(input op_t op);
        return (op == W1) || (op == R1);
    endfunction

endpackage

// File: rtl/march_bist_addr_gen.sv
// Loadable up/down address counter for the March engine. Load puts the
// counter at 0 (up) or N-1 (down); last flags the final address of the
// current direction.
module march_bist_addr_gen #(
    parameter int P_ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    load,
    input  logic                    load_down,
    input  logic                    step,
    input  logic                    down,
    output logic [P_ADDR_WIDTH-1:0] addr,
    output logic                    last
);

    localparam logic [P_ADDR_WIDTH-1:0] ADDR_ONE = P_ADDR_WIDTH'(1);

    logic [P_ADDR_WIDTH-1:0] addr_reg;

    // Address register: load has priority over step
    always_ff @(posedge clk) begin
        if (srst) begin
            addr_reg <= '0;
        end else if (load) begin
            addr_reg <= load_down ? '1 : '0;
        end else if (step) begin
            addr_reg <= down ? (addr_reg - ADDR_ONE) : (addr_reg + ADDR_ONE);
        end
    end

    assign addr = addr_reg;
    assign last = down ? (addr_reg == '0) : (addr_reg == '1);

endmodule

// File: rtl/rm_ihpsg13_march_bist_ctrl.sv
// March C- BIST engine for a 1P SRAM macro with BIST mux. Issues one op per
// cycle on the A_BIST_* port and compares A_DOUT one cycle after each read.
// Optional first-failure log enabled by defining MARCH_BIST_FAIL_LOG_EN.
module rm_ihpsg13_march_bist_ctrl
    import march_bist_pkg::*;
#(
    parameter int P_DATA_WIDTH = 16,
    parameter int P_ADDR_WIDTH = 8
) (
    input  logic                    A_BIST_CLK,
    input  logic                    A_BIST_RST,
    input  logic                    BIST_START,
    output logic                    BIST_BUSY,
    output logic                    BIST_DONE,
    output logic                    BIST_FAIL,
    output logic [P_ADDR_WIDTH-1:0] BIST_FAIL_ADDR,
    output logic [2:0]              BIST_FAIL_ELEM,
    output logic [P_DATA_WIDTH-1:0] BIST_FAIL_BITS,
    output logic                    A_BIST_EN,
    output logic                    A_BIST_MEN,
    output logic                    A_BIST_WEN,
    output logic                    A_BIST_REN,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
    input  logic [P_DATA_WIDTH-1:0] A_DOUT
);

    state_t    state_reg, state_next;
    elem_t     elem_reg, elem_next;
    logic      op_idx_reg, op_idx_next;
    elem_cfg_t cfg;
    op_t       cur_op;
    logic      launch;
    logic      ag_load, ag_load_down, ag_step, ag_last;
    logic [P_ADDR_WIDTH-1:0] ag_addr;

    logic      pend_reg;
    logic      exp_reg;
    logic      fail_reg;
    logic      mismatch;

    assign cfg      = elem_cfg(elem_reg);
    assign cur_op   = op_idx_reg ? cfg.op1 : cfg.op0;
    assign launch   = ((state_reg == IDLE) || (state_reg == DONE)) && BIST_START;
    assign mismatch = pend_reg && (A_DOUT != {P_DATA_WIDTH{exp_reg}});

    march_bist_addr_gen #(
        .P_ADDR_WIDTH(P_ADDR_WIDTH)
    ) u_addr_gen (
        .clk      (A_BIST_CLK),
        .srst     (A_BIST_RST),
        .load     (ag_load),
        .load_down(ag_load_down),
        .step     (ag_step),
        .down     (cfg.down),
        .addr     (ag_addr),
        .last     (ag_last)
    );

    // FSM state, element index and op-within-address index
    always_ff @(posedge A_BIST_CLK) begin
        if (A_BIST_RST) begin
            state_reg  <= IDLE;
            elem_reg   <= '0;
            op_idx_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            elem_reg   <= elem_next;
            op_idx_reg <= op_idx_next;
        end
    end

    // Next-state sequencing and macro-port drive; element change costs no cycle
    always_comb begin
        state_next   = state_reg;
        elem_next    = elem_reg;
        op_idx_next  = op_idx_reg;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;
        A_BIST_EN    = 1'b0;
        A_BIST_MEN   = 1'b0;
        A_BIST_WEN   = 1'b0;
        A_BIST_REN   = 1'b0;
        A_BIST_ADDR  = '0;
        A_BIST_DIN   = '0;
        A_BIST_BM    = '0;
        case (state_reg)
            IDLE, DONE: begin
                if (BIST_START) begin
                    state_next   = RUN;
                    elem_next    = '0;
                    op_idx_next  = 1'b0;
                    ag_load      = 1'b1;
                    ag_load_down = elem_cfg(3'd0).down;
                end
            end
            RUN: begin
                A_BIST_EN   = 1'b1;
                A_BIST_MEN  = 1'b1;
                A_BIST_WEN  = op_is_write(cur_op);
                A_BIST_REN  = !op_is_write(cur_op);
                A_BIST_ADDR = ag_addr;
                if (op_is_write(cur_op)) begin
                    A_BIST_DIN = {P_DATA_WIDTH{op_value(cur_op)}};
                    A_BIST_BM  = '1;
                end
                if (op_idx_reg == cfg.two_ops) begin
                    op_idx_next = 1'b0;
                    if (ag_last) begin
                        if (elem_reg == elem_t'(NUM_ELEM - 1)) begin
                            state_next = DRAIN;
                        end else begin
                            elem_next    = elem_reg + 3'd1;
                            ag_load      = 1'b1;
                            ag_load_down = elem_cfg(elem_reg + 3'd1).down;
                        end
                    end else begin
                        ag_step = 1'b1;
                    end
                end else begin
                    op_idx_next = 1'b1;
                end
            end
            DRAIN: begin
                A_BIST_EN  = 1'b1;
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Read pipeline: register expectation at the read edge, compare next edge
    always_ff @(posedge A_BIST_CLK) begin
        if (A_BIST_RST) begin
            pend_reg <= 1'b0;
            exp_reg  <= 1'b0;
            fail_reg <= 1'b0;
        end else if (launch) begin
            pend_reg <= 1'b0;
            exp_reg  <= 1'b0;
            fail_reg <= 1'b0;
        end else begin
            pend_reg <= (state_reg == RUN) && !op_is_write(cur_op);
            exp_reg  <= op_value(cur_op);
            if (mismatch) begin
                fail_reg <= 1'b1;
            end
        end
    end

`ifdef MARCH_BIST_FAIL_LOG_EN
    logic [P_ADDR_WIDTH-1:0] pend_addr_reg;
    elem_t                   pend_elem_reg;
    logic [P_ADDR_WIDTH-1:0] log_addr_reg;
    elem_t                   log_elem_reg;
    logic [P_DATA_WIDTH-1:0] log_bits_reg;

    // First-mismatch capture; later mismatches leave the log untouched
    always_ff @(posedge A_BIST_CLK) begin
        if (A_BIST_RST || launch) begin
            pend_addr_reg <= '0;
            pend_elem_reg <= '0;
            log_addr_reg  <= '0;
            log_elem_reg  <= '0;
            log_bits_reg  <= '0;
        end else begin
            pend_addr_reg <= ag_addr;
            pend_elem_reg <= elem_reg;
            if (mismatch && !fail_reg) begin
                log_addr_reg <= pend_addr_reg;
                log_elem_reg <= pend_elem_reg;
                log_bits_reg <= A_DOUT ^ {P_DATA_WIDTH{exp_reg}};
            end
        end
    end

    assign BIST_FAIL_ADDR = log_addr_reg;
    assign BIST_FAIL_ELEM = log_elem_reg;
    assign BIST_FAIL_BITS = log_bits_reg;
`else
    assign BIST_FAIL_ADDR = '0;
    assign BIST_FAIL_ELEM = '0;
    assign BIST_FAIL_BITS = '0;
`endif

    assign BIST_BUSY = (state_reg == RUN) || (state_reg == DRAIN);
    assign BIST_DONE = (state_reg == DONE);
    assign BIST_FAIL = fail_reg;

endmodule
